// File: rtl/adder_seq_pkg.sv
// rtl/adder_seq_pkg.sv - shared widths and FSM state type for the multi-precision adder sequencer
package adder_seq_pkg;

    localparam int WORD_W  = 32;
    localparam int SLICE_W = 8;
    localparam int NSLICE  = WORD_W / SLICE_W;
    localparam int CNT_W   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/adder_seq_ctrl_adder.sv
// rtl/adder_seq_ctrl_adder.sv - 8-bit combinational Adder slice with carry in/out
module adder_seq_ctrl_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] iData_a,
    input  logic [W-1:0] iData_b,
    input  logic         iC,
    output logic [W-1:0] oData,
    output logic         oData_C
);

    assign {oData_C, oData} = {1'b0, iData_a} + {1'b0, iData_b} + {{W{1'b0}}, iC};

endmodule

// File: rtl/adder_seq_ctrl.sv
// rtl/adder_seq_ctrl.sv - 32-bit add/subtract sequenced one byte per cycle through a single Adder slice
module adder_seq_ctrl
    import adder_seq_pkg::*;
(
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iStart,
    input  logic              iSub,
    input  logic [WORD_W-1:0] iData_a,
    input  logic [WORD_W-1:0] iData_b,
    input  logic              iC,
    output logic              oReady,
    output logic              oBusy,
    output logic              oDone,
    output logic [WORD_W-1:0] oData,
    output logic              oData_C,
    output logic              oOvf
);

    localparam int              MSB  = WORD_W - 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                carry_q, carry_d;
    logic [WORD_W-1:0]   a_q, a_d;
    logic [WORD_W-1:0]   b_q, b_d;
    logic [WORD_W-1:0]   acc_q, acc_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic                c_q, c_d;
    logic                ovf_q, ovf_d;

    logic [SLICE_W-1:0]  sl_a, sl_b, sl_sum;
    logic                sl_co;

    assign sl_a = a_q[int'(cnt_q) * SLICE_W +: SLICE_W];
    assign sl_b = b_q[int'(cnt_q) * SLICE_W +: SLICE_W];

    adder_seq_ctrl_adder #(.W(SLICE_W)) u_adder (
        .iData_a (sl_a),
        .iData_b (sl_b),
        .iC      (carry_q),
        .oData   (sl_sum),
        .oData_C (sl_co)
    );

    // Partial bytes accumulate in acc_q so the visible result only moves on DONE entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        data_d  = data_q;
        c_d     = c_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (iStart) begin
                    a_d     = iData_a;
                    b_d     = iSub ? ~iData_b : iData_b;
                    carry_d = iSub ? 1'b1 : iC;
                    cnt_d   = '0;
                    data_d  = '0;
                    c_d     = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d[int'(cnt_q) * SLICE_W +: SLICE_W] = sl_sum;
                carry_d = sl_co;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    data_d  = acc_d;
                    c_d     = sl_co;
                    ovf_d   = (a_q[MSB] == b_q[MSB]) && (sl_sum[SLICE_W-1] != a_q[MSB]);
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            c_q     <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            c_q     <= c_d;
            ovf_q   <= ovf_d;
        end
    end

    assign oReady  = (state_q == IDLE);
    assign oBusy   = (state_q == RUN);
    assign oDone   = (state_q == DONE);
    assign oData   = data_q;
    assign oData_C = c_q;
    assign oOvf    = ovf_q;

endmodule

// File: doc/adder_seq_ctrl.md
Name: adder_seq_ctrl

Overview:
Multi-precision add/subtract sequencer that reuses the team's existing 8-bit Adder slice to produce a 32-bit result. It processes one byte per cycle, least-significant slice first. The carry is held in a register between slices. A start/ready/done handshake lets a simple FSM or CPU-side block issue one operation at a time. The block sits between the operand source and the existing combinational Adder, and is the only driver of that Adder's inputs.

Parameters:
WORD_W, 32, operand/result width; must be a multiple of SLICE_W.
SLICE_W, 8, width of one Adder pass; fixed to the Adder datapath width.
NSLICE, WORD_W/SLICE_W (derived, 4), number of Adder passes per operation.

Ports:
iClk  in  1  clock, rising edge.
iRst_n  in  1  reset; asynchronous, active-low.
iStart  in  1  request an operation; sampled only while oReady=1.
iSub  in  1  0: oData = A + B + iC; 1: oData = A - B, i.e. A + ~B + 1 (iC ignored).
iData_a  in  WORD_W  operand A.
iData_b  in  WORD_W  operand B.
iC  in  1  carry-in for add.
oReady  out  1  high in IDLE only.
oBusy  out  1  high in RUN.
oDone  out  1  single-cycle pulse in DONE.
oData  out  WORD_W  result.
oData_C  out  1  carry-out of the MSB slice. For subtract, 0 means a borrow occurred.
oOvf  out  1  signed two's-complement overflow.

Behaviour:
- States: IDLE, RUN, DONE. Reset and abort both go to IDLE.
- Reset (asynchronous, iRst_n=0):
  - state=IDLE, slice counter=0, carry register=0.
  - Operand registers, oData, oData_C and oOvf all clear to 0.
  - oDone=0, oBusy=0, oReady=1.
- Reset asserted mid-operation aborts it. No oDone is produced and the partial result is discarded.
- IDLE, on iStart=1:
  - Latch A=iData_a and B'=(iSub ? ~iData_b : iData_b).
  - Carry register = (iSub ? 1 : iC); counter = 0.
  - Clear the result register; go to RUN.
- IDLE, on iStart=0: stay; outputs hold the last result.
- RUN (one slice per cycle, k = counter):
  - Adder inputs: A[k*8+:8], B'[k*8+:8] and the carry register.
  - Next edge: result[k*8+:8] <= Adder sum; carry register <= Adder carry-out; counter++.
  - When k = NSLICE-1, go to DONE on that same edge.
- DONE (exactly one cycle):
  - oDone=1. oData holds the full result; oData_C = final carry.
  - oOvf = (A[MSB] == B'[MSB]) && (oData[MSB] != A[MSB]).
  - Go to IDLE.
- Latency: accept edge at cycle 0, RUN in cycles 1..NSLICE, oDone in cycle NSLICE+1 (cycle 5 by default).
- Throughput: one operation per NSLICE+2 cycles; a new iStart is accepted in the IDLE cycle after DONE.
- iStart while oReady=0 (RUN or DONE) is ignored and not queued.
- Operand inputs may change after the accept edge without affecting the operation in flight.
- oData, oData_C and oOvf are registered. They change only at the DONE entry edge (updated), the accept edge (result cleared) and on reset. They are stable from DONE until the next accept.
- Arithmetic: modulo 2^WORD_W. Carry propagates strictly through the carry register; there is no combinational chain across slices.

Decomposition:
- Package adder_seq_pkg:
  - state enum {IDLE, RUN, DONE}.
  - Constants WORD_W, SLICE_W, NSLICE.
  - Counter width $clog2(NSLICE).
- Sub-module: a single instance of the existing Adder (8-bit slice: iData_a, iData_b, iC, oData, oData_C).
- The FSM, counter, operand/result registers and overflow logic live in adder_seq_ctrl.

Test Plan:
1. Basic add with timing: A=0x00000001, B=0x00000001, iC=0, add -> oData=0x00000002, oData_C=0, oOvf=0. oDone pulses exactly 5 cycles after accept; oBusy is high for exactly 4 cycles.
2. Full carry ripple: A=0xFFFFFFFF, B=0x00000001 -> oData=0x00000000, oData_C=1, oOvf=0. Repeat with A=0x000000FF, B=0, iC=1 -> oData=0x00000100.
3. Signed overflow: A=0x7FFFFFFF, B=0x00000001 -> oData=0x80000000, oData_C=0, oOvf=1. Also A=0xFFFFFFFF, B=0xFFFFFFFF -> oData=0xFFFFFFFE, oData_C=1, oOvf=0.
4. Subtract with borrow: iSub=1, A=0x00000005, B=0x00000007, iC=1 (ignored) -> oData=0xFFFFFFFE, oData_C=0, oOvf=0. Also A=0x80000000, B=0x00000001 -> oData=0x7FFFFFFF, oOvf=1.
5. Handshake rules:
   - Hold iStart=1 with new operands through RUN/DONE -> the first result is unaffected and no extra oDone appears.
   - The second operation is accepted in the IDLE cycle after DONE, and its result is correct.
6. Reset mid-operation: assert iRst_n=0 during RUN slice 2 -> outputs 0, oReady=1, no oDone. After release, 0x12345678 + 0x11111111 -> 0x23456789.
